// File: rtl/midi_voice_scheduler.sv
// MIDI voice scheduler: parses the UART byte stream (with running status)
// and maps Note On / Note Off onto a fixed pool of voice slots, allocating
// free slots first and stealing round-robin when the pool is full.
module midi_voice_scheduler #(
    parameter int VOICES  = 4,
    parameter int MIDI_CH = 0,
    parameter int OMNI    = 0
) (
    input  logic                  i_clk,
    input  logic                  i_res_n,
    input  logic                  i_rxDone,
    input  logic [7:0]            i_rxData,
    output logic [VOICES-1:0]     o_voice_on,
    output logic [7*VOICES-1:0]   o_voice_note,
    output logic [7*VOICES-1:0]   o_voice_vel,
    output logic                  o_event,
    output logic                  o_steal
);

    localparam int          PW   = (VOICES > 2) ? $clog2(VOICES) : 1;
    localparam logic [PW-1:0] LAST = PW'(VOICES - 1);
    localparam logic [3:0]  CH   = 4'(MIDI_CH);

    // parser state
    logic [7:0] r_status;
    logic       r_need2;   // 1: message carries two data bytes
    logic       r_cnt;
    logic [6:0] r_d1;

    // voice state
    logic [VOICES-1:0]   on_q;
    logic [7*VOICES-1:0] note_q, vel_q;
    logic [PW-1:0]       ptr_q;

    logic [VOICES-1:0]   nx_on;
    logic [7*VOICES-1:0] nx_note, nx_vel;
    logic [PW-1:0]       nx_ptr;
    logic                nx_steal, nx_event;

    logic       is_data, complete, ch_ok, exec;
    logic [3:0] typ;
    logic [6:0] msg_n, msg_v;
    logic       note_on, note_off, all_off;

    assign o_voice_on   = on_q;
    assign o_voice_note = note_q;
    assign o_voice_vel  = vel_q;

    // decode the message completed by the current byte, if any
    always_comb begin
        is_data  = ~i_rxData[7];
        complete = i_rxDone && is_data && (r_status != 8'h00) && (!r_need2 || r_cnt);
        ch_ok    = (OMNI != 0) || (r_status[3:0] == CH);
        exec     = complete && ch_ok;
        typ      = r_status[7:4];
        msg_v    = i_rxData[6:0];
        msg_n    = r_need2 ? r_d1 : i_rxData[6:0];
        note_on  = exec && (typ == 4'h9) && (msg_v != 7'd0);
        note_off = exec && ((typ == 4'h8) || ((typ == 4'h9) && (msg_v == 7'd0)));
        all_off  = exec && (typ == 4'hB) && (r_d1 == 7'd123);
    end

    // next voice state: retrigger, allocate, steal or release
    always_comb begin
        int  hit_i, free_i, idx;
        logic hit, free;
        nx_on    = on_q;
        nx_note  = note_q;
        nx_vel   = vel_q;
        nx_ptr   = ptr_q;
        nx_steal = 1'b0;
        hit      = 1'b0;
        free     = 1'b0;
        hit_i    = 0;
        free_i   = 0;
        idx      = 0;
        // scan downwards so the lowest index wins
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (on_q[i] && (note_q[7*i +: 7] == msg_n)) begin
                hit   = 1'b1;
                hit_i = i;
            end
            if (!on_q[i]) begin
                free   = 1'b1;
                free_i = i;
            end
        end
        if (note_on) begin
            if (hit) begin
                nx_vel[7*hit_i +: 7] = msg_v;
            end else if (free) begin
                nx_on[free_i]          = 1'b1;
                nx_note[7*free_i +: 7] = msg_n;
                nx_vel[7*free_i +: 7]  = msg_v;
            end else begin
                idx                 = int'(ptr_q);
                nx_on[idx]          = 1'b1;
                nx_note[7*idx +: 7] = msg_n;
                nx_vel[7*idx +: 7]  = msg_v;
                nx_steal            = 1'b1;
                nx_ptr              = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
            end
        end else if (note_off) begin
            for (int i = 0; i < VOICES; i++) begin
                if (on_q[i] && (note_q[7*i +: 7] == msg_n)) begin
                    nx_on[i]          = 1'b0;
                    nx_vel[7*i +: 7]  = 7'd0;
                end
            end
        end else if (all_off) begin
            nx_on  = '0;
            nx_vel = '0;
        end
        nx_event = (nx_on != on_q) || (nx_note != note_q) || (nx_vel != vel_q);
    end

    // byte parser with running status; realtime bytes pass straight through
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            r_status <= 8'h00;
            r_need2  <= 1'b1;
            r_cnt    <= 1'b0;
            r_d1     <= 7'd0;
        end else if (i_rxDone) begin
            if (i_rxData >= 8'hF8) begin
                r_status <= r_status;
            end else if (i_rxData >= 8'hF0) begin
                r_status <= 8'h00;
                r_cnt    <= 1'b0;
            end else if (i_rxData[7]) begin
                r_status <= i_rxData;
                r_cnt    <= 1'b0;
                r_need2  <= !((i_rxData[7:4] == 4'hC) || (i_rxData[7:4] == 4'hD));
            end else if (r_status != 8'h00) begin
                if (r_need2 && !r_cnt) begin
                    r_d1  <= i_rxData[6:0];
                    r_cnt <= 1'b1;
                end else begin
                    r_cnt <= 1'b0;
                end
            end
        end
    end

    // voice registers and one-cycle event/steal strobes
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            on_q    <= '0;
            note_q  <= '0;
            vel_q   <= '0;
            ptr_q   <= '0;
            o_event <= 1'b0;
            o_steal <= 1'b0;
        end else begin
            on_q    <= nx_on;
            note_q  <= nx_note;
            vel_q   <= nx_vel;
            ptr_q   <= nx_ptr;
            o_event <= nx_event;
            o_steal <= nx_steal;
        end
    end

endmodule

// File: doc/midi_voice_scheduler.md
Name: midi_voice_scheduler

Overview:
- Sits directly after the UART receiver in the MIDI path. Consumes its byte stream (done pulse plus data byte).
- Parses MIDI channel messages, including running status.
- Schedules Note On / Note Off events onto a fixed pool of VOICES tone-generator slots: allocates free slots, retriggers duplicate notes, steals round-robin when the pool is full.
- Per-voice gate/note/velocity registers drive the tone generators.

Parameters:
- VOICES, 4, number of voice slots (2..8).
- MIDI_CH, 0, accepted MIDI channel (0..15) when OMNI=0.
- OMNI, 0, 1 = accept all 16 channels.

Ports:
- i_clk  input  1  system clock.
- i_res_n  input  1  reset, asynchronous, active-low.
- i_rxDone  input  1  one-cycle pulse: i_rxData holds a new received byte.
- i_rxData  input  8  received byte.
- o_voice_on  output  VOICES  gate per voice, bit v = voice v sounding.
- o_voice_note  output  7*VOICES  note number, voice v at [7v+6:7v].
- o_voice_vel  output  7*VOICES  velocity, same packing.
- o_event  output  1  one-cycle pulse when any voice register changed.
- o_steal  output  1  one-cycle pulse when a Note On stole a busy voice.

Behaviour:
- One clock (i_clk), reset asynchronous, active-low (i_res_n).
- Reset values (async assert, any time, including mid-message):
  - o_voice_on=0, o_voice_note=0, o_voice_vel=0, o_event=0, o_steal=0.
  - Running status cleared, byte counter=0, steal pointer=0.
- Input timing: i_rxDone pulses are at least 2 cycles apart. Bytes arriving at the UART rate always satisfy this.
- Parser state: r_status (8b, 0 = none), r_need (data bytes expected: 1 or 2), r_cnt (0/1), r_d1 (7b).
- Byte classification, evaluated only when i_rxDone=1:
  - 0xF8..0xFF (realtime): ignored completely. r_status, r_cnt and r_d1 are unchanged.
  - 0xF0..0xF7: r_status=0, r_cnt=0. Following data bytes are discarded until the next channel status.
  - 0x80..0xEF: r_status=byte, r_cnt=0.
    - r_need=1 for 0xCn/0xDn, else 2.
    - Status is tracked even for rejected channels and types, so data-byte counting stays correct.
  - Data byte (bit7=0) with r_status=0: discarded.
  - Data byte, r_cnt=0 and r_need=2: r_d1=byte, r_cnt=1.
  - Data byte completing a message: r_cnt=0 (running status retained). The message executes if its channel is accepted (OMNI=1 or low nibble = MIDI_CH).
- Executed messages (n=r_d1, v=final byte):
  - 0x9n with v≠0 (Note On):
    1. If any voice has on=1 and note=n, the lowest such voice gets vel=v (retrigger, no new allocation).
    2. Else the lowest-index voice with on=0 gets note=n, vel=v, on=1.
    3. Else the voice at the steal pointer gets note=n, vel=v, on=1. o_steal pulses. The steal pointer increments and wraps from VOICES-1 to 0.
  - 0x9n with v=0, or 0x8n (Note Off): every voice with on=1 and note=n gets on=0, vel=0; note is retained. No match: no change, no o_event.
  - 0xBn with d1=123 (All Notes Off): all on=0, all vel=0.
  - All other messages: no effect.
- Latency: voice registers, o_event and o_steal update on the same clock edge that samples i_rxDone=1 with the completing byte (1-cycle registered). o_event and o_steal are high for exactly the following cycle only.
- Only one message can complete per cycle, so no simultaneous-event arbitration is needed.
- The steal pointer advances only on a steal. Allocation and release never move it.

Test Plan:
- Reset, then bytes 90 3C 64 → voice0 on, note=0x3C, vel=0x64; o_event one cycle; others off.
- Running status: 90 3C 64, 40 50, 3C 00 → voice0 off after the third message, voice1 stays note 0x40 vel 0x50; o_voice_on=0b0010.
- Full pool (VOICES=4): Note On 0x30..0x33, then 0x34 and 0x35 → voice0=0x34, voice1=0x35. o_steal pulses twice; the steal pointer ends at 2.
- Interleaving and filtering:
  - F8 between 90 and 3C, and between 3C and 64 → Note On still executes.
  - Same on channel 1 (91 …) with OMNI=0, MIDI_CH=0 → no change.
  - F0 40 50 → ignored.
- Retrigger, then All Notes Off: 90 3C 10, 90 3C 7F → only voice0 used, vel=0x7F. Then B0 7B 00 → all off, all vel=0.
- Reset asserted asynchronously between data bytes 3C and 64 with voices active → all outputs 0 immediately. After release, a lone 64 is discarded.
